// File: rtl/vga_stream_sync_ctrl.sv
// Read-side controller for the video output FIFO: generates VGA raster timing,
// aligns the FIFO stream to frame boundaries and resyncs on underflow or misalignment.
module vga_stream_sync_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int LEVEL_W  = 11,
    parameter int PREFILL  = 256
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic               fifo_empty_i,
    input  logic [LEVEL_W-1:0] fifo_level_i,
    input  logic               fifo_sof_i,
    output logic               fifo_rd_en_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               active_video_o,
    output logic               pixel_valid_o,
    output logic               locked_o,
    output logic [15:0]        underflow_cnt_o,
    output logic [15:0]        align_err_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        FILL = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } state_t;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_active_video;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_first_pix;
    state_t        r_state;
    logic [15:0]   r_underflow_cnt;
    logic [15:0]   r_align_err_cnt;

    state_t        w_next_state;
    logic          w_rd;
    logic          w_underflow;
    logic          w_misalign;
    logic          w_err;
    logic          w_frame_last;
    logic          w_hsync_on;
    logic          w_vsync_on;

    assign w_frame_last = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign w_hsync_on   = (int'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                          (int'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign w_vsync_on   = (int'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                          (int'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Raster outputs lag the counters by one clock; first_pix tags pixel (0,0).
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_active_video <= 1'b0;
            r_hsync        <= ~SYNC_ON;
            r_vsync        <= ~SYNC_ON;
            r_first_pix    <= 1'b0;
        end else begin
            r_active_video <= (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
            r_hsync        <= w_hsync_on ? SYNC_ON : ~SYNC_ON;
            r_vsync        <= w_vsync_on ? SYNC_ON : ~SYNC_ON;
            r_first_pix    <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // SOF must coincide exactly with the first pixel of the frame.
    assign w_err = (r_first_pix && !fifo_sof_i) || (!r_first_pix && fifo_sof_i);

    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_underflow  = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            SEEK: begin
                w_rd = !fifo_empty_i && !fifo_sof_i;
                if (!fifo_empty_i && fifo_sof_i) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (int'(fifo_level_i) >= PREFILL) begin
                    w_next_state = ARM;
                end
            end
            ARM: begin
                if (w_frame_last) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_active_video) begin
                    if (fifo_empty_i) begin
                        w_underflow  = 1'b1;
                        w_next_state = SEEK;
                    end else if (w_err) begin
                        w_misalign   = 1'b1;
                        w_next_state = SEEK;
                    end else begin
                        w_rd = 1'b1;
                    end
                end
            end
            default: w_next_state = SEEK;
        endcase
    end

    // Error counters saturate rather than wrap.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_underflow_cnt <= '0;
            r_align_err_cnt <= '0;
        end else begin
            if (w_underflow && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
            if (w_misalign && (r_align_err_cnt != 16'hFFFF)) begin
                r_align_err_cnt <= r_align_err_cnt + 16'd1;
            end
        end
    end

    // Gated by reset so the cycle in which reset is sampled never pops the FIFO.
    assign fifo_rd_en_o    = w_rd && s_axis_aresetn;
    assign pixel_valid_o   = w_rd && s_axis_aresetn && (r_state == RUN);
    assign hsync_o         = r_hsync;
    assign vsync_o         = r_vsync;
    assign active_video_o  = r_active_video;
    assign locked_o        = (r_state == RUN);
    assign underflow_cnt_o = r_underflow_cnt;
    assign align_err_cnt_o = r_align_err_cnt;

endmodule

// File: tb/tb_vga_stream_sync_ctrl.sv
// Testbench for vga_stream_sync_ctrl on a 14x7 raster with a behavioural
// first-word-fall-through FIFO that stores one SOF bit per word.
module tb_vga_stream_sync_ctrl;

    localparam int FRAME = 98;

    logic        clock = 1'b0;
    logic        aresetn = 1'b0;
    logic        fifo_empty_i;
    logic [10:0] fifo_level_i;
    logic        fifo_sof_i;
    logic        fifo_rd_en_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        active_video_o;
    logic        pixel_valid_o;
    logic        locked_o;
    logic [15:0] underflow_cnt_o;
    logic [15:0] align_err_cnt_o;

    logic        useModel = 1'b0;
    logic        ovEmpty = 1'b1;
    logic        ovSof = 1'b0;
    bit          memSof [4096];
    int          rdPtr = 0;
    int          wrPtr = 0;
    int          popCount = 0;
    int          edgeCount = 0;
    bit          popEmpty = 1'b0;

    int          total = 0;
    int          bad = 0;

    typedef struct {
        int   k;
        logic act;
        logic hs;
        logic vs;
    } rasterVec_t;

    typedef struct {
        logic empty;
        logic sof;
        logic rd;
    } seekVec_t;

    rasterVec_t rasterTab [12];
    seekVec_t   seekTab [4];

    vga_stream_sync_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .LEVEL_W(11), .PREFILL(8)
    ) dut (
        .s_axis_aclk     (clock),
        .s_axis_aresetn  (aresetn),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_level_i    (fifo_level_i),
        .fifo_sof_i      (fifo_sof_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .hsync_o         (hsync_o),
        .vsync_o         (vsync_o),
        .active_video_o  (active_video_o),
        .pixel_valid_o   (pixel_valid_o),
        .locked_o        (locked_o),
        .underflow_cnt_o (underflow_cnt_o),
        .align_err_cnt_o (align_err_cnt_o)
    );

    always #5 clock = ~clock;

    // FIFO flags come either from the model or from direct overrides.
    assign fifo_empty_i = useModel ? (wrPtr == rdPtr) : ovEmpty;
    assign fifo_sof_i   = useModel ? memSof[rdPtr[11:0]] : ovSof;
    assign fifo_level_i = useModel ? 11'(wrPtr - rdPtr) : 11'd0;

    always @(posedge clock) begin
        edgeCount <= aresetn ? edgeCount + 1 : 0;
        if (fifo_rd_en_o) begin
            if (useModel) begin
                rdPtr <= rdPtr + 1;
            end
            popCount <= popCount + 1;
            if (fifo_empty_i) begin
                popEmpty <= 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pushes nWords into the model FIFO; the first carries SOF when withSof is set.
    task automatic applyStimulus(input int nWords, input bit withSof);
        for (int i = 0; i < nWords; i++) begin
            memSof[wrPtr[11:0]] = withSof && (i == 0);
            wrPtr = wrPtr + 1;
        end
    endtask

    task automatic waitLocked(input logic level, input int limit, input string name);
        int guard;
        guard = 0;
        while ((locked_o !== level) && (guard < limit)) begin
            tick();
            guard++;
        end
        checkOutput(name, locked_o, level);
    endtask

    task automatic runUnderflow(input string name);
        applyStimulus(8, 1'b1);
        waitLocked(1'b1, 300, {name, "_lock"});
        waitLocked(1'b0, 300, {name, "_unlock"});
    endtask

    initial begin
        int prevK;
        int pop0;
        int hsLow;
        int vsLow;
        int guard;
        logic lastRd;

        rasterTab[0]  = '{1,  1'b1, 1'b1, 1'b1};
        rasterTab[1]  = '{8,  1'b1, 1'b1, 1'b1};
        rasterTab[2]  = '{9,  1'b0, 1'b1, 1'b1};
        rasterTab[3]  = '{11, 1'b0, 1'b0, 1'b1};
        rasterTab[4]  = '{12, 1'b0, 1'b0, 1'b1};
        rasterTab[5]  = '{13, 1'b0, 1'b1, 1'b1};
        rasterTab[6]  = '{15, 1'b1, 1'b1, 1'b1};
        rasterTab[7]  = '{57, 1'b0, 1'b1, 1'b1};
        rasterTab[8]  = '{71, 1'b0, 1'b1, 1'b0};
        rasterTab[9]  = '{84, 1'b0, 1'b1, 1'b0};
        rasterTab[10] = '{85, 1'b0, 1'b1, 1'b1};
        rasterTab[11] = '{99, 1'b1, 1'b1, 1'b1};

        seekTab[0] = '{1'b1, 1'b0, 1'b0};
        seekTab[1] = '{1'b1, 1'b1, 1'b0};
        seekTab[2] = '{1'b0, 1'b0, 1'b1};
        seekTab[3] = '{1'b0, 1'b1, 1'b0};

        aresetn = 1'b0;
        @(posedge clock);
        tick();
        checkOutput("rst_active", active_video_o, 1'b0);
        checkOutput("rst_syncs", {hsync_o, vsync_o}, 2'b11);
        checkOutput("rst_locked", locked_o, 1'b0);
        checkOutput("rst_counts", {underflow_cnt_o, align_err_cnt_o}, 32'd0);
        aresetn = 1'b1;

        prevK = 0;
        for (int i = 0; i < 12; i++) begin
            repeat (rasterTab[i].k - prevK) tick();
            prevK = rasterTab[i].k;
            checkOutput($sformatf("raster_k%0d", rasterTab[i].k),
                        {active_video_o, hsync_o, vsync_o},
                        {rasterTab[i].act, rasterTab[i].hs, rasterTab[i].vs});
        end
        checkOutput("raster_unlocked", locked_o, 1'b0);

        for (int i = 0; i < 4; i++) begin
            tick();
            ovEmpty = seekTab[i].empty;
            ovSof   = seekTab[i].sof;
            #1;
            checkOutput($sformatf("seek_rd_e%0d_s%0d", seekTab[i].empty, seekTab[i].sof),
                        fifo_rd_en_o, seekTab[i].rd);
            ovEmpty = 1'b1;
            ovSof   = 1'b0;
        end

        // Five stale words ahead of the SOF, then too few words to arm.
        tick();
        useModel = 1'b1;
        pop0 = popCount;
        applyStimulus(5, 1'b0);
        applyStimulus(3, 1'b1);
        repeat (12) tick();
        checkOutput("seek_drop_pops", popCount - pop0, 5);
        checkOutput("fill_head_sof", fifo_sof_i, 1'b1);
        checkOutput("fill_unlocked", locked_o, 1'b0);

        applyStimulus(29, 1'b0);
        applyStimulus(32, 1'b1);
        waitLocked(1'b1, 300, "lock1");
        checkOutput("lock1_at_wrap", edgeCount % FRAME, 0);
        checkOutput("lock1_first_active", active_video_o, 1'b0);

        pop0  = popCount;
        hsLow = 0;
        vsLow = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i == 0) begin
                checkOutput("first_pix_valid", {active_video_o, pixel_valid_o}, 2'b11);
            end
            hsLow += (hsync_o == 1'b0) ? 1 : 0;
            vsLow += (vsync_o == 1'b0) ? 1 : 0;
        end
        checkOutput("frame_reads", popCount - pop0, 32);
        checkOutput("hsync_low", hsLow, 14);
        checkOutput("vsync_low", vsLow, 14);
        checkOutput("frame_counts", {underflow_cnt_o, align_err_cnt_o}, 32'd0);

        // Only ten pixels of the third frame arrive: mid-frame underflow.
        applyStimulus(10, 1'b1);
        guard = 0;
        while (!(active_video_o && fifo_empty_i) && (guard < 400)) begin
            tick();
            guard++;
        end
        checkOutput("uf_reached", active_video_o && fifo_empty_i, 1'b1);
        checkOutput("uf_cycle_locked", locked_o, 1'b1);
        checkOutput("uf_cycle_rd", {fifo_rd_en_o, pixel_valid_o}, 2'b00);
        tick();
        checkOutput("uf_count", underflow_cnt_o, 16'd1);
        checkOutput("uf_unlocked", locked_o, 1'b0);
        checkOutput("uf_align", align_err_cnt_o, 16'd0);

        // A 31-pixel frame followed by a good one.
        applyStimulus(31, 1'b1);
        applyStimulus(32, 1'b1);
        waitLocked(1'b1, 300, "lock2");
        pop0   = popCount;
        lastRd = 1'b0;
        guard  = 0;
        while (locked_o && (guard < 200)) begin
            lastRd = fifo_rd_en_o;
            tick();
            guard++;
        end
        checkOutput("mis_unlocked", locked_o, 1'b0);
        checkOutput("mis_count", align_err_cnt_o, 16'd1);
        checkOutput("mis_uf_count", underflow_cnt_o, 16'd1);
        checkOutput("mis_pops", popCount - pop0, 31);
        checkOutput("mis_err_cycle_rd", lastRd, 1'b0);
        checkOutput("mis_sof_kept", fifo_sof_i, 1'b1);
        waitLocked(1'b1, 300, "relock");
        checkOutput("relock_at_wrap", edgeCount % FRAME, 0);

        // Reset while pixels are being read.
        guard = 0;
        while (!fifo_rd_en_o && (guard < 50)) begin
            tick();
            guard++;
        end
        checkOutput("run_reading", fifo_rd_en_o, 1'b1);
        pop0 = popCount;
        aresetn = 1'b0;
        #1;
        checkOutput("rst_cycle_rd", fifo_rd_en_o, 1'b0);
        tick();
        checkOutput("rst_run_pops", popCount - pop0, 0);
        checkOutput("rst_run_outs",
                    {active_video_o, hsync_o, vsync_o, locked_o, pixel_valid_o},
                    5'b01100);
        checkOutput("rst_run_counts", {underflow_cnt_o, align_err_cnt_o}, 32'd0);
        wrPtr = rdPtr;
        aresetn = 1'b1;

        // Preload the counter near saturation, then underflow twice.
        force dut.r_underflow_cnt = 16'hFFFE;
        #1;
        release dut.r_underflow_cnt;
        runUnderflow("sat1");
        checkOutput("sat_first", underflow_cnt_o, 16'hFFFF);
        runUnderflow("sat2");
        checkOutput("sat_hold", underflow_cnt_o, 16'hFFFF);
        checkOutput("sat_align", align_err_cnt_o, 16'd0);

        checkOutput("no_pop_when_empty", popEmpty, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
